uart_tx_digit: RTL and testbench

- Serial UART transmitter (8N1) that sends the classification result byte from the final fully-connected layer to the host.
- Samples the layer's level-held `trmt` and `dout` byte, then shifts the frame out on `TX`.
- Returns a single-cycle `tx_done` pulse. The layer uses this pulse to clear its counters, argmax registers and state machine, and to return to idle.
- Sits at the top level between the layer-5 datapath and the DE0-Nano GPIO UART pin.

---
 rtl/uart_tx_digit.sv | 96 +++++++++
 tb/tb_uart_tx_digit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_digit.sv
// 8N1 UART transmitter that sends the layer-5 classification byte to the host.
// It captures a level-held request and returns a one-cycle tx_done pulse at the end of the frame.
module uart_tx_digit #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned CNT_W    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] BAUD_TC = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       LAST_BIT = 4'd9;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [9:0]       r_sr;
  logic [CNT_W-1:0] r_baud;
  logic [3:0]       r_bit;
  logic             r_done;
  logic             w_capture;
  logic             w_shift;
  logic             w_finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Terminal counts use >= so a forced out-of-range counter still ends the frame.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_shift     = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (trmt && !r_done) begin
          w_capture   = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (r_baud >= BAUD_TC) begin
          w_shift = 1'b1;
          if (r_bit >= LAST_BIT) begin
            w_finish    = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr   <= '1;
      r_baud <= '0;
      r_bit  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_capture) begin
        r_sr   <= {1'b1, tx_data, 1'b0};
        r_baud <= '0;
        r_bit  <= '0;
      end else if (r_state == SEND) begin
        if (w_shift) begin
          r_baud <= '0;
          r_sr   <= {1'b1, r_sr[9:1]};
          r_bit  <= w_finish ? 4'd0 : r_bit + 4'd1;
        end else begin
          r_baud <= r_baud + 1'b1;
        end
      end
    end
  end

  assign TX      = r_sr[0];
  assign tx_busy = (r_state == SEND);
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_digit.sv
// Bench for uart_tx_digit: a fast-divisor instance and a default-divisor instance,
// with a receiver model per line feeding a byte scoreboard keyed on tx_done.
module tb_uart_tx_digit;

  logic       clk;
  logic       rst_n;
  logic       a_trmt, b_trmt;
  logic [7:0] a_data, b_data;
  logic       a_tx, a_busy, a_done;
  logic       b_tx, b_busy, b_done;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  logic [9:0] rx_sh   [2];
  int         rx_cnt  [2];
  bit         rx_act  [2];
  bit         rx_have [2];

  uart_tx_digit #(.BAUD_DIV(4), .CNT_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .trmt(a_trmt), .tx_data(a_data),
    .TX(a_tx), .tx_busy(a_busy), .tx_done(a_done)
  );

  uart_tx_digit #(.BAUD_DIV(434), .CNT_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .trmt(b_trmt), .tx_data(b_data),
    .TX(b_tx), .tx_busy(b_busy), .tx_done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_trmt(input int id, input logic v);
    if (id == 0) a_trmt = v;
    else b_trmt = v;
  endtask

  task automatic set_data(input int id, input logic [7:0] v);
    if (id == 0) a_data = v;
    else b_data = v;
  endtask

  task automatic chk_outs(input int id, input string tag, input logic tx, input logic busy,
                          input logic done);
    if (id == 0) begin
      chk({tag, "_a_tx"}, a_tx, tx);
      chk({tag, "_a_busy"}, a_busy, busy);
      chk({tag, "_a_done"}, a_done, done);
    end else begin
      chk({tag, "_b_tx"}, b_tx, tx);
      chk({tag, "_b_busy"}, b_busy, busy);
      chk({tag, "_b_done"}, b_done, done);
    end
  endtask

  // Receiver model: samples mid-bit; the scoreboard pops an expected byte on each tx_done.
  task automatic rx_step(input int id, input logic tx, input logic done, input int div);
    int idx;
    logic [7:0] e;
    if (!rst_n) begin
      rx_act[id]  = 1'b0;
      rx_have[id] = 1'b0;
      return;
    end
    if (!rx_act[id]) begin
      if (!tx) begin
        rx_act[id] = 1'b1;
        rx_cnt[id] = 0;
      end
    end else begin
      rx_cnt[id]++;
    end
    if (rx_act[id] && (rx_cnt[id] % div == div / 2)) begin
      idx = rx_cnt[id] / div;
      rx_sh[id][idx] = tx;
      if (idx == 9) begin
        rx_act[id]  = 1'b0;
        rx_have[id] = 1'b1;
      end
    end
    if (done) begin
      e = 8'h00;
      if (id == 0) begin
        chk("sb_a_done_expected", int'(exp_q0.size() > 0), 1);
        if (exp_q0.size() > 0) e = exp_q0.pop_front();
      end else begin
        chk("sb_b_done_expected", int'(exp_q1.size() > 0), 1);
        if (exp_q1.size() > 0) e = exp_q1.pop_front();
      end
      chk("sb_frame_complete", int'(rx_have[id]), 1);
      chk("sb_start_stop", int'({rx_sh[id][9], rx_sh[id][0]}), 2);
      chk("sb_byte", int'(rx_sh[id][8:1]), int'(e));
      rx_have[id] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    rx_step(0, a_tx, a_done, 4);
    rx_step(1, b_tx, b_done, 434);
  end

  // Drives one frame and checks TX/busy/done every cycle; cycle 0 is the trmt sampling cycle.
  task automatic run_frame(input int id, input logic [7:0] data, input bit hold, input bit chg);
    int div;
    int last;
    logic [9:0] fr;
    logic exp_tx;
    div  = (id == 0) ? 4 : 434;
    last = 10 * div + 4;
    fr   = {1'b1, data, 1'b0};
    cyc();
    set_data(id, data);
    set_trmt(id, 1'b1);
    if (id == 0) exp_q0.push_back(data);
    else exp_q1.push_back(data);
    for (int c = 1; c <= last; c++) begin
      cyc();
      if (c == 1 && !hold) set_trmt(id, 1'b0);
      if (c == 10 * div + 2) set_trmt(id, 1'b0);
      if (chg && c == 10) set_data(id, 8'hFF);
      if (chg && c == 12) set_trmt(id, 1'b1);
      if (chg && c == 14) set_trmt(id, 1'b0);
      exp_tx = (c <= 10 * div) ? fr[(c - 1) / div] : 1'b1;
      chk_outs(id, "frame", exp_tx, (c <= 10 * div), (c == 10 * div + 1));
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    a_trmt = 1'b1;
    b_trmt = 1'b1;
    a_data = 8'h00;
    b_data = 8'h00;
    repeat (3) cyc();
    chk_outs(0, "reset", 1'b1, 1'b0, 1'b0);
    chk_outs(1, "reset", 1'b1, 1'b0, 1'b0);
    a_trmt = 1'b0;
    b_trmt = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      chk_outs(0, "idle", 1'b1, 1'b0, 1'b0);
    end

    run_frame(0, 8'h07, 1'b0, 1'b0);
    run_frame(0, 8'h03, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk_outs(0, "held_after", 1'b1, 1'b0, 1'b0);
    end
    run_frame(0, 8'hA5, 1'b0, 1'b1);

    cyc();
    a_data = 8'h00;
    a_trmt = 1'b1;
    exp_q0.push_back(8'h00);
    cyc();
    a_trmt = 1'b0;
    repeat (14) cyc();
    chk("midrst_pre_tx", a_tx, 0);
    chk("midrst_pre_busy", a_busy, 1);
    rst_n = 1'b0;
    void'(exp_q0.pop_back());
    #1;
    chk_outs(0, "midrst_async", 1'b1, 1'b0, 1'b0);
    repeat (3) cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc();
      chk_outs(0, "midrst_after", 1'b1, 1'b0, 1'b0);
    end
    run_frame(0, 8'h3C, 1'b0, 1'b0);

    run_frame(1, 8'h09, 1'b0, 1'b0);

    repeat (5) cyc();
    chk("sb_a_drained", exp_q0.size(), 0);
    chk("sb_b_drained", exp_q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
